layer_engine_arbiter: RTL

Shares one sequential MAC layer engine (start/done, 128-in x 32-out Q8.8 dense layer) between NREQ requesters, e.g. the real-sample path and the generator fake-sample path of the discriminator. It performs round-robin arbitration and latches the winner's input vector, holding it stable for the whole computation. It pulses the engine start, waits for done, then returns the captured result tagged with the requester id.

---
 rtl/gan_ctrl_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 29 ++
 rtl/layer_engine_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gan_ctrl_pkg.sv
// Shared constants for the discriminator layer-engine control path: FSM encoding,
// Q8.8 word width, dense-layer dimensions and the default watchdog limit.
package gan_ctrl_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLaunch = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
  localparam logic [2:0] StErr    = 3'd4;

  localparam int unsigned QWidth        = 16;
  localparam int unsigned EngNumIn      = 128;
  localparam int unsigned EngNumOut     = 32;
  localparam int unsigned DefTimeoutCyc = 8192;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_priority_picker #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic [IdW-1:0]  win_idx_o,
  output logic            any_o
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr_i) + off) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o         = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/layer_engine_arbiter.sv
// Round-robin share of one start/done MAC layer engine between NREQ requesters.
// Optional watchdog on the WAIT state: define LAYER_ARB_WATCHDOG_EN.
module layer_engine_arbiter
  import gan_ctrl_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned IN_W        = EngNumIn * QWidth,
  parameter int unsigned OUT_W       = EngNumOut * QWidth,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
  localparam int unsigned IdW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*IN_W-1:0] req_data_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 rsp_valid_o,
  output logic [IdW-1:0]       rsp_id_o,
  output logic [OUT_W-1:0]     rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 eng_start_o,
  output logic [IN_W-1:0]      eng_in_o,
  input  logic [OUT_W-1:0]     eng_out_i,
  input  logic                 eng_done_i
);

  logic [2:0]       state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   cur_id_q, cur_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             eng_start_q, eng_start_d;
  logic [IdW-1:0]   rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic [IN_W-1:0]  eng_in_q, eng_in_d;
`ifdef LAYER_ARB_WATCHDOG_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  logic [NREQ-1:0]  win_oh;
  logic [IdW-1:0]   win_idx;
  logic             win_any;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    eng_start_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    eng_in_d    = eng_in_q;
`ifdef LAYER_ARB_WATCHDOG_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          gnt_d    = win_oh;
          cur_id_d = win_idx;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) eng_in_d = req_data_i[i*IN_W +: IN_W];
          end
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        eng_start_d = 1'b1;
        state_d     = StWait;
`ifdef LAYER_ARB_WATCHDOG_EN
        cnt_d       = '0;
`endif
      end
      StWait: begin
        // A done coinciding with the timeout still completes normally.
        if (eng_done_i) begin
          rsp_data_d  = eng_out_i;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = StDone;
        end
`ifdef LAYER_ARB_WATCHDOG_EN
        else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          rsp_err_d = 1'b1;
          rsp_id_d  = cur_id_q;
          state_d   = StErr;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      StDone: begin
        ptr_d   = IdW'((32'(cur_id_q) + 1) % NREQ);
        state_d = StIdle;
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      eng_in_q    <= '0;
`ifdef LAYER_ARB_WATCHDOG_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      eng_start_q <= eng_start_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      eng_in_q    <= eng_in_d;
`ifdef LAYER_ARB_WATCHDOG_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign eng_start_o = eng_start_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign eng_in_o    = eng_in_q;

endmodule
